// File: rtl/regs_gen_if.sv
// Register-file bus: clear request/status, two write ports and two read ports.
// The master drives addresses, enables and write data; the slave returns the read data and busy.
interface regs_gen_if #(
  parameter int N  = 8,
  parameter int AW = 5
);
  logic          clr;
  logic          busy;
  logic          w1;
  logic [AW-1:0] Waddr1;
  logic [N-1:0]  Wdata1;
  logic          w2;
  logic [AW-1:0] Waddr2;
  logic [N-1:0]  Wdata2;
  logic [AW-1:0] Raddr1;
  logic [AW-1:0] Raddr2;
  logic [N-1:0]  Rdata1;
  logic [N-1:0]  Rdata2;

  modport master (
    output clr, w1, Waddr1, Wdata1, w2, Waddr2, Wdata2, Raddr1, Raddr2,
    input  busy, Rdata1, Rdata2
  );

  modport slave (
    input  clr, w1, Waddr1, Wdata1, w2, Waddr2, Wdata2, Raddr1, Raddr2,
    output busy, Rdata1, Rdata2
  );
endinterface

// File: rtl/regs_gen.sv
// pMIPS register file: 2**AW x N, two async reads, two sync writes. The storage has no reset;
// a sequential sweep zeroes it after reset or on clr.
module regs_gen #(
  parameter int N        = 8,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 0
) (
  input logic     clk,
  input logic     reset,
  regs_gen_if.slave rf
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  mem_q [DEPTH];
  logic          run;
  logic          we1, we2;
  logic [N-1:0]  stored1, stored2;

  function automatic logic [N-1:0] read_sel(
    input logic [AW-1:0] ra,
    input logic [N-1:0]  stored,
    input logic          running,
    input logic          wen1,
    input logic [AW-1:0] wa1,
    input logic [N-1:0]  wd1,
    input logic          wen2,
    input logic [AW-1:0] wa2,
    input logic [N-1:0]  wd2
  );
    logic [N-1:0] r;
    r = stored;
    if (!running) r = '0;
    else if (ZERO_REG != 0 && ra == '0) r = '0;
    else if (BYPASS != 0 && wen1 && wa1 == ra) r = wd1;
    else if (BYPASS != 0 && wen2 && wa2 == ra) r = wd2;
    return r;
  endfunction

  assign run = (state_q == ST_RUN);
  assign we1 = run && rf.w1 && !(ZERO_REG != 0 && rf.Waddr1 == '0);
  assign we2 = run && rf.w2 && !(ZERO_REG != 0 && rf.Waddr2 == '0);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == ST_CLEAR) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == LAST) begin
        state_d = ST_RUN;
        ptr_d   = '0;
      end
    end else if (rf.clr) begin
      state_d = ST_CLEAR;
      ptr_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Port 1 is written last so it wins an address collision with port 2.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem_q[ptr_q] <= '0;
    end else begin
      if (we2) mem_q[rf.Waddr2] <= rf.Wdata2;
      if (we1) mem_q[rf.Waddr1] <= rf.Wdata1;
    end
  end

  assign stored1   = mem_q[rf.Raddr1];
  assign stored2   = mem_q[rf.Raddr2];
  assign rf.busy   = (state_q == ST_CLEAR);
  assign rf.Rdata1 = read_sel(rf.Raddr1, stored1, run, rf.w1, rf.Waddr1, rf.Wdata1,
                              rf.w2, rf.Waddr2, rf.Wdata2);
  assign rf.Rdata2 = read_sel(rf.Raddr2, stored2, run, rf.w1, rf.Waddr1, rf.Wdata1,
                              rf.w2, rf.Waddr2, rf.Wdata2);
endmodule

// File: tb/tb_regs_gen.sv
// Directed bench for regs_gen: dut_a is ZERO_REG=1/BYPASS=0, dut_b is ZERO_REG=0/BYPASS=1,
// both fed by the same stimulus.
module tb_regs_gen;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  regs_gen_if #(.N(8), .AW(5)) ifa ();
  regs_gen_if #(.N(8), .AW(5)) ifb ();

  assign ifb.clr    = ifa.clr;
  assign ifb.w1     = ifa.w1;
  assign ifb.Waddr1 = ifa.Waddr1;
  assign ifb.Wdata1 = ifa.Wdata1;
  assign ifb.w2     = ifa.w2;
  assign ifb.Waddr2 = ifa.Waddr2;
  assign ifb.Wdata2 = ifa.Wdata2;
  assign ifb.Raddr1 = ifa.Raddr1;
  assign ifb.Raddr2 = ifa.Raddr2;

  regs_gen #(.N(8), .AW(5), .ZERO_REG(1), .BYPASS(0)) dut_a (.clk(clk), .reset(reset), .rf(ifa));
  regs_gen #(.N(8), .AW(5), .ZERO_REG(0), .BYPASS(1)) dut_b (.clk(clk), .reset(reset), .rf(ifb));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    ifa.clr = 1'b0; ifa.w1 = 1'b0; ifa.w2 = 1'b0;
    ifa.Waddr1 = '0; ifa.Wdata1 = '0; ifa.Waddr2 = '0; ifa.Wdata2 = '0;
  endtask

  // Counts edges until both DUTs leave the sweep; bounded so a stuck DUT cannot hang the bench.
  task automatic count_sweep(input string name, output int na, output int nb);
    na = 0; nb = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (ifa.busy && na == 0) ifa.Raddr1 = ifa.Raddr1;
      if (!ifa.busy && na == 0) na = i;
      if (!ifb.busy && nb == 0) nb = i;
      if (na != 0 && nb != 0) begin
        ifa.w1 = 1'b0;
        break;
      end
    end
    checks++;
    if (na !== 32) begin errors++; $display("FAIL %s_a edges got %0d want 32", name, na); end
    checks++;
    if (nb !== 32) begin errors++; $display("FAIL %s_b edges got %0d want 32", name, nb); end
  endtask

  task automatic test_reset;
    int na, nb;
    idle_inputs();
    ifa.Raddr1 = 5'd4; ifa.Raddr2 = 5'd9;
    reset = 1'b1;
    tick(); tick();
    checks++;
    if (ifa.busy !== 1'b1 || ifb.busy !== 1'b1) begin
      errors++; $display("FAIL reset_busy got %b/%b want 1/1", ifa.busy, ifb.busy);
    end
    checks++;
    if (ifa.Rdata1 !== 8'h00 || ifb.Rdata2 !== 8'h00) begin
      errors++; $display("FAIL reset_rdata got %h/%h want 00/00", ifa.Rdata1, ifb.Rdata2);
    end
    reset = 1'b0;
    count_sweep("reset_sweep", na, nb);
    for (int a = 0; a < 32; a++) begin
      ifa.Raddr1 = 5'(a); ifa.Raddr2 = 5'(31 - a);
      #1;
      checks++;
      if (ifa.Rdata1 !== 8'h00 || ifa.Rdata2 !== 8'h00 || ifb.Rdata1 !== 8'h00 || ifb.Rdata2 !== 8'h00) begin
        errors++;
        $display("FAIL zero_after_sweep addr %0d got %h %h %h %h want 00", a,
                 ifa.Rdata1, ifa.Rdata2, ifb.Rdata1, ifb.Rdata2);
      end
    end
  endtask

  task automatic test_dual_write;
    ifa.w1 = 1'b1; ifa.Waddr1 = 5'd1; ifa.Wdata1 = 8'd11;
    ifa.w2 = 1'b1; ifa.Waddr2 = 5'd2; ifa.Wdata2 = 8'd12;
    tick();
    idle_inputs();
    ifa.Raddr1 = 5'd1; ifa.Raddr2 = 5'd2;
    #1;
    checks++;
    if (ifa.Rdata1 !== 8'd11 || ifb.Rdata1 !== 8'd11) begin
      errors++; $display("FAIL dual_write_r1 got %h/%h want 0b", ifa.Rdata1, ifb.Rdata1);
    end
    checks++;
    if (ifa.Rdata2 !== 8'd12 || ifb.Rdata2 !== 8'd12) begin
      errors++; $display("FAIL dual_write_r2 got %h/%h want 0c", ifa.Rdata2, ifb.Rdata2);
    end
  endtask

  task automatic test_collision;
    ifa.w1 = 1'b1; ifa.Waddr1 = 5'd3; ifa.Wdata1 = 8'hAA;
    ifa.w2 = 1'b1; ifa.Waddr2 = 5'd3; ifa.Wdata2 = 8'h55;
    ifa.Raddr1 = 5'd3; ifa.Raddr2 = 5'd3;
    #1;
    checks++;
    if (ifa.Rdata1 !== 8'h00 || ifb.Rdata1 !== 8'hAA) begin
      errors++; $display("FAIL collision_pre got %h/%h want 00/aa", ifa.Rdata1, ifb.Rdata1);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (ifa.Rdata2 !== 8'hAA || ifb.Rdata2 !== 8'hAA) begin
      errors++; $display("FAIL collision_post got %h/%h want aa/aa", ifa.Rdata2, ifb.Rdata2);
    end
  endtask

  task automatic test_zero_reg;
    ifa.w1 = 1'b1; ifa.Waddr1 = 5'd0; ifa.Wdata1 = 8'hFF;
    ifa.Raddr2 = 5'd0;
    #1;
    checks++;
    if (ifa.Rdata2 !== 8'h00 || ifb.Rdata2 !== 8'hFF) begin
      errors++; $display("FAIL zero_reg_pre got %h/%h want 00/ff", ifa.Rdata2, ifb.Rdata2);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (ifa.Rdata2 !== 8'h00 || ifb.Rdata2 !== 8'hFF) begin
      errors++; $display("FAIL zero_reg_post got %h/%h want 00/ff", ifa.Rdata2, ifb.Rdata2);
    end
  endtask

  task automatic test_bypass;
    ifa.w1 = 1'b1; ifa.Waddr1 = 5'd5; ifa.Wdata1 = 8'h3C;
    ifa.w2 = 1'b1; ifa.Waddr2 = 5'd6; ifa.Wdata2 = 8'h5A;
    ifa.Raddr1 = 5'd5; ifa.Raddr2 = 5'd6;
    #1;
    checks++;
    if (ifa.Rdata1 !== 8'h00 || ifb.Rdata1 !== 8'h3C) begin
      errors++; $display("FAIL bypass_p1_pre got %h/%h want 00/3c", ifa.Rdata1, ifb.Rdata1);
    end
    checks++;
    if (ifa.Rdata2 !== 8'h00 || ifb.Rdata2 !== 8'h5A) begin
      errors++; $display("FAIL bypass_p2_pre got %h/%h want 00/5a", ifa.Rdata2, ifb.Rdata2);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (ifa.Rdata1 !== 8'h3C || ifb.Rdata1 !== 8'h3C || ifa.Rdata2 !== 8'h5A || ifb.Rdata2 !== 8'h5A) begin
      errors++;
      $display("FAIL bypass_post got %h %h %h %h want 3c 3c 5a 5a",
               ifa.Rdata1, ifb.Rdata1, ifa.Rdata2, ifb.Rdata2);
    end
  endtask

  task automatic test_clear;
    int na, nb;
    ifa.clr = 1'b1;
    ifa.w1 = 1'b1; ifa.Waddr1 = 5'd7; ifa.Wdata1 = 8'h99;
    tick();
    ifa.clr = 1'b0;
    ifa.Waddr1 = 5'd1; ifa.Wdata1 = 8'h77;
    ifa.Raddr1 = 5'd1; ifa.Raddr2 = 5'd7;
    #1;
    checks++;
    if (ifa.busy !== 1'b1 || ifb.busy !== 1'b1) begin
      errors++; $display("FAIL clear_busy got %b/%b want 1/1", ifa.busy, ifb.busy);
    end
    checks++;
    if (ifa.Rdata1 !== 8'h00 || ifb.Rdata1 !== 8'h00) begin
      errors++; $display("FAIL clear_rdata_busy got %h/%h want 00/00", ifa.Rdata1, ifb.Rdata1);
    end
    count_sweep("clr_sweep", na, nb);
    idle_inputs();
    ifa.clr = 1'b1;
    #1;
    ifa.clr = 1'b0;
    for (int a = 1; a <= 7; a++) begin
      ifa.Raddr1 = 5'(a); ifa.Raddr2 = 5'(a);
      #1;
      checks++;
      if (ifa.Rdata1 !== 8'h00 || ifb.Rdata1 !== 8'h00 || ifb.Rdata2 !== 8'h00) begin
        errors++; $display("FAIL cleared_reg %0d got %h/%h want 00", a, ifa.Rdata1, ifb.Rdata1);
      end
    end
  endtask

  task automatic test_reset_mid_sweep;
    int na, nb;
    ifa.clr = 1'b1;
    tick();
    ifa.clr = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    #1;
    checks++;
    if (ifa.busy !== 1'b1 || ifb.busy !== 1'b1) begin
      errors++; $display("FAIL mid_reset_busy got %b/%b want 1/1", ifa.busy, ifb.busy);
    end
    tick(); tick();
    reset = 1'b0;
    count_sweep("mid_reset_sweep", na, nb);
    ifa.w1 = 1'b1; ifa.Waddr1 = 5'd9; ifa.Wdata1 = 8'h42;
    tick();
    idle_inputs();
    ifa.Raddr1 = 5'd9;
    #1;
    checks++;
    if (ifa.Rdata1 !== 8'h42 || ifb.Rdata1 !== 8'h42) begin
      errors++; $display("FAIL run_after_reset got %h/%h want 42/42", ifa.Rdata1, ifb.Rdata1);
    end
  endtask

  initial begin
    test_reset();
    test_dual_write();
    test_collision();
    test_zero_reg();
    test_bypass();
    test_clear();
    test_dual_write();
    test_reset_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
